// File: rtl/mem_bist.sv
// Two-pass march BIST master (write/read seed^addr, then its inverse) driving a valid/ready memory port.
// Latency: one request per cycle when ready is high; done appears 4*DEPTH cycles after the start edge.
// Backpressure: holds the request stable while ready is low; aborts to DONE after TIMEOUT wait cycles.
module mem_bist #(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int WIDTH      = 16,
   parameter int TIMEOUT    = 32,
   parameter int ERR_W      = $clog2(2*DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      seed,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  wr_rd,
   output logic [WIDTH-1:0]      wdata,
   output logic                  valid,
   input  logic [WIDTH-1:0]      rdata,
   input  logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [ERR_W-1:0]      err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic                  first_err_pass
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WR0  = 3'd1;
   localparam logic [2:0] S_RD0  = 3'd2;
   localparam logic [2:0] S_WR1  = 3'd3;
   localparam logic [2:0] S_RD1  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam int TW = $clog2(TIMEOUT+1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH-1);
   localparam logic [ERR_W-1:0]      ERR_MAX   = '1;
   localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT-1);

   logic [2:0]            state_q, state_d;
   logic [WIDTH-1:0]      seed_q, seed_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_rd_q, wr_rd_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  pass_q, pass_d;
   logic                  timeout_q, timeout_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic [ADDR_WIDTH-1:0] fea_q, fea_d;
   logic                  fep_q, fep_d;
   logic [TW-1:0]         tmo_q, tmo_d;

   logic                  xfer;
   logic                  cur_inv;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // Pass-0 pattern is seed ^ address; pass 1 uses its bitwise inverse.
   function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] s,
                                                input logic inv,
                                                input logic [ADDR_WIDTH-1:0] a);
      logic [WIDTH-1:0] p;
      p = s ^ WIDTH'(a);
      return inv ? ~p : p;
   endfunction

   assign xfer     = valid_q && ready;
   assign cur_inv  = (state_q == S_WR1) || (state_q == S_RD1);
   assign addr_inc = addr_q + 1'b1;

   // Next-state logic: start acceptance, march sequencing, read compare and ready timeout.
   always_comb begin
      state_d   = state_q;
      seed_d    = seed_q;
      addr_d    = addr_q;
      wr_rd_d   = wr_rd_q;
      wdata_d   = wdata_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      err_d     = err_q;
      fea_d     = fea_q;
      fep_d     = fep_q;
      tmo_d     = tmo_q;

      if (state_q == S_IDLE || state_q == S_DONE) begin
         if (start) begin
            state_d   = S_WR0;
            seed_d    = seed;
            addr_d    = '0;
            wr_rd_d   = 1'b1;
            wdata_d   = seed;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            err_d     = '0;
            fea_d     = '0;
            fep_d     = 1'b0;
            tmo_d     = '0;
         end
      end else if (xfer) begin
         tmo_d = '0;
         if (!wr_rd_q && (rdata != pattern(seed_q, cur_inv, addr_q))) begin
            // Only the very first mismatch of a run records its location.
            if (err_q == '0) begin
               fea_d = addr_q;
               fep_d = cur_inv;
            end
            if (err_q != ERR_MAX) begin
               err_d = err_q + 1'b1;
            end
         end
         if (addr_q == ADDR_LAST) begin
            addr_d = '0;
            case (state_q)
               S_WR0: begin
                  state_d = S_RD0;
                  wr_rd_d = 1'b0;
                  wdata_d = pattern(seed_q, 1'b0, '0);
               end
               S_RD0: begin
                  state_d = S_WR1;
                  wr_rd_d = 1'b1;
                  wdata_d = pattern(seed_q, 1'b1, '0);
               end
               S_WR1: begin
                  state_d = S_RD1;
                  wr_rd_d = 1'b0;
                  wdata_d = pattern(seed_q, 1'b1, '0);
               end
               default: begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end
            endcase
         end else begin
            addr_d  = addr_inc;
            wdata_d = pattern(seed_q, cur_inv, addr_inc);
         end
      end else if (valid_q) begin
         if (tmo_q == TMO_LAST) begin
            state_d   = S_DONE;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
            tmo_d     = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // State and output registers; reset abandons any in-flight request immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         seed_q    <= '0;
         addr_q    <= '0;
         wr_rd_q   <= 1'b0;
         wdata_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         err_q     <= '0;
         fea_q     <= '0;
         fep_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         seed_q    <= seed_d;
         addr_q    <= addr_d;
         wr_rd_q   <= wr_rd_d;
         wdata_q   <= wdata_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         err_q     <= err_d;
         fea_q     <= fea_d;
         fep_q     <= fep_d;
         tmo_q     <= tmo_d;
      end
   end

   assign addr           = addr_q;
   assign wr_rd          = wr_rd_q;
   assign wdata          = wdata_q;
   assign valid          = valid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = timeout_q;
   assign err_count      = err_q;
   assign first_err_addr = fea_q;
   assign first_err_pass = fep_q;

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: ideal memory model with optional stuck bit, wait states and stuck ready.
// Latency under test: 4*DEPTH cycles clean, 3x that with two wait states per transfer, 41 cycles to timeout.
// Backpressure: ready is generated by the bench; request stability is watched while ready is low.
module tb_mem_bist;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int W     = 16;
   localparam int EW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  seed;
   logic [AW-1:0] addr;
   logic          wr_rd;
   logic [W-1:0]  wdata;
   logic          valid;
   logic [W-1:0]  rdata;
   logic          ready;
   logic          busy, done, pass, timeout;
   logic [EW-1:0] err_count;
   logic [AW-1:0] first_err_addr;
   logic          first_err_pass;

   mem_bist #(.DEPTH(DEPTH), .WIDTH(W), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .addr(addr), .wr_rd(wr_rd), .wdata(wdata), .valid(valid),
      .rdata(rdata), .ready(ready), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_count(err_count),
      .first_err_addr(first_err_addr), .first_err_pass(first_err_pass)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int miscmp  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model and ready generation
   logic [W-1:0] mem [DEPTH];
   logic         wait_mode  = 1'b0;
   logic         stuck_mode = 1'b0;
   logic         fault_mode = 1'b0;
   logic [1:0]   wc = 2'd0;
   logic [W-1:0] exp_seed = '0;

   always_comb begin
      rdata = mem[addr];
      if (fault_mode && addr == 6'd5) rdata = rdata & 16'hFFF7;
   end

   always_comb begin
      if (wait_mode) ready = (wc == 2'd2);
      else           ready = !(stuck_mode && wr_rd && addr == 6'd9);
   end

   always @(posedge clk) begin
      if (valid && ready && wr_rd) mem[addr] <= wdata;
      if (valid && !ready) wc <= wc + 2'd1;
      else                 wc <= 2'd0;
   end

   // Monitor: transfer counts, address/data order, address-3 captures, stability while stalled
   logic         mon_clr = 1'b1;
   int           xcnt = 0, wcnt = 0, rcnt = 0, seq_bad = 0, stable_bad = 0;
   logic [W-1:0] w3_p0 = '0, w3_p1 = '0;
   logic         stalled = 1'b0;
   logic [AW-1:0] s_addr = '0;
   logic          s_wr = 1'b0;
   logic [W-1:0]  s_wdata = '0;

   function automatic logic [W-1:0] exp_pat(input logic [W-1:0] s, input int k);
      logic [W-1:0] p;
      p = s ^ W'(k % DEPTH);
      return (k >= DEPTH) ? ~p : p;
   endfunction

   always @(negedge clk) begin
      if (mon_clr) begin
         xcnt <= 0; wcnt <= 0; rcnt <= 0; seq_bad <= 0; stable_bad <= 0;
         w3_p0 <= '0; w3_p1 <= '0; stalled <= 1'b0;
      end else if (valid) begin
         if (stalled && (addr != s_addr || wr_rd != s_wr || wdata != s_wdata))
            stable_bad <= stable_bad + 1;
         stalled <= !ready;
         s_addr  <= addr; s_wr <= wr_rd; s_wdata <= wdata;
         if (ready) begin
            xcnt <= xcnt + 1;
            if (wr_rd) begin
               if (addr != AW'(wcnt % DEPTH) || wdata != exp_pat(exp_seed, wcnt))
                  seq_bad <= seq_bad + 1;
               if (addr == 6'd3) begin
                  if (wcnt < DEPTH) w3_p0 <= wdata;
                  else              w3_p1 <= wdata;
               end
               wcnt <= wcnt + 1;
            end else begin
               if (addr != AW'(rcnt % DEPTH)) seq_bad <= seq_bad + 1;
               rcnt <= rcnt + 1;
            end
         end
      end else begin
         stalled <= 1'b0;
      end
   end

   task automatic start_run(input logic [W-1:0] s);
      mon_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1 mon_clr = 1'b0;
      exp_seed = s;
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int cyc);
      cyc = 0;
      while (!done && cyc < maxc) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk("run_ends", {31'd0, done}, 32'd1);
   endtask

   int cyc;
   int guard;

   initial begin
      rst = 1'b0; start = 1'b0; seed = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_busy",  {31'd0, busy}, 0);
      chk("rst_done",  {31'd0, done}, 0);
      chk("rst_pass",  {31'd0, pass}, 0);
      chk("rst_err",   {24'd0, err_count}, 0);
      chk("rst_wdata", {16'd0, wdata}, 0);
      @(negedge clk) rst = 1'b1;

      // Clean run
      start_run(16'hA5A5);
      chk("st_busy",  {31'd0, busy}, 1);
      chk("st_valid", {31'd0, valid}, 1);
      chk("st_wr",    {31'd0, wr_rd}, 1);
      chk("st_addr",  {26'd0, addr}, 0);
      chk("st_wdata", {16'd0, wdata}, 32'hA5A5);
      wait_done(2000, cyc);
      chk("clean_cycles", cyc, 256);
      chk("clean_pass",   {31'd0, pass}, 1);
      chk("clean_err",    {24'd0, err_count}, 0);
      chk("clean_busy",   {31'd0, busy}, 0);
      chk("clean_valid",  {31'd0, valid}, 0);
      chk("clean_tmo",    {31'd0, timeout}, 0);
      chk("clean_xfers",  xcnt, 256);
      chk("clean_seq",    seq_bad, 0);
      chk("clean_w3_p0",  {16'd0, w3_p0}, 32'hA5A6);
      chk("clean_w3_p1",  {16'd0, w3_p1}, 32'h5A59);

      // Stuck bit 3 at address 5
      fault_mode = 1'b1;
      start_run(16'h00FF);
      wait_done(2000, cyc);
      chk("stuck_cycles", cyc, 256);
      chk("stuck_err",    {24'd0, err_count}, 1);
      chk("stuck_fea",    {26'd0, first_err_addr}, 5);
      chk("stuck_fep",    {31'd0, first_err_pass}, 0);
      chk("stuck_pass",   {31'd0, pass}, 0);
      fault_mode = 1'b0;

      // Two wait states before every transfer
      wait_mode = 1'b1;
      start_run(16'h1357);
      wait_done(3000, cyc);
      chk("wait_cycles", cyc, 768);
      chk("wait_pass",   {31'd0, pass}, 1);
      chk("wait_stable", stable_bad, 0);
      chk("wait_xfers",  xcnt, 256);
      chk("wait_seq",    seq_bad, 0);
      wait_mode = 1'b0;

      // Ready stuck low at write address 9
      stuck_mode = 1'b1;
      start_run(16'h0F0F);
      wait_done(500, cyc);
      chk("tmo_cycles", cyc, 41);
      chk("tmo_valid",  {31'd0, valid}, 0);
      chk("tmo_flag",   {31'd0, timeout}, 1);
      chk("tmo_done",   {31'd0, done}, 1);
      chk("tmo_pass",   {31'd0, pass}, 0);
      chk("tmo_busy",   {31'd0, busy}, 0);
      chk("tmo_xfers",  xcnt, 9);
      stuck_mode = 1'b0;

      // Start pulse during RD0 is ignored
      start_run(16'hC3C3);
      guard = 0;
      while (rcnt < 10 && guard < 500) begin @(negedge clk); guard++; end
      chk("busy_reach_rd0", {31'd0, (rcnt >= 10)}, 1);
      @(negedge clk);
      seed = 16'h1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0; seed = 16'hC3C3;
      wait_done(2000, cyc);
      chk("ign_pass",  {31'd0, pass}, 1);
      chk("ign_xfers", xcnt, 256);
      chk("ign_seq",   seq_bad, 0);

      // Reset during WR1
      start_run(16'h5555);
      guard = 0;
      while (wcnt < DEPTH + 5 && guard < 500) begin @(negedge clk); guard++; end
      chk("rst_reach_wr1", {31'd0, (wcnt >= DEPTH + 5)}, 1);
      #2 rst = 1'b0;
      #1;
      chk("mrst_valid", {31'd0, valid}, 0);
      chk("mrst_busy",  {31'd0, busy}, 0);
      chk("mrst_addr",  {26'd0, addr}, 0);
      chk("mrst_wr",    {31'd0, wr_rd}, 0);
      chk("mrst_wdata", {16'd0, wdata}, 0);
      chk("mrst_flags", {28'd0, done, pass, timeout, first_err_pass}, 0);
      chk("mrst_fea",   {26'd0, first_err_addr}, 0);
      @(negedge clk) rst = 1'b1;
      start_run(16'h2468);
      wait_done(2000, cyc);
      chk("after_rst_cycles", cyc, 256);
      chk("after_rst_pass",   {31'd0, pass}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end
endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test master that sits directly upstream of `memory` and drives its valid/ready request port. On a start pulse it performs a two-pass march: it writes a seed-derived pattern to every address, then reads it back and compares. It then repeats with the inverted pattern. It reports pass/fail, an error count, and the first failing location. A per-request timeout covers a memory that never asserts ready.

## Interface
- `DEPTH`, 64: number of memory words; addresses 0..DEPTH-1.
- `ADDR_WIDTH`, $clog2(DEPTH): memory address width.
- `WIDTH`, 16: memory data width.
- `TIMEOUT`, 32: maximum cycles a request may wait for ready before the run aborts.
- `ERR_W`, $clog2(2*DEPTH+1): error counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle start request.
- `seed` in WIDTH: pattern seed, latched when start is accepted.
- `addr` out ADDR_WIDTH: memory address.
- `wr_rd` out 1: 1 = write, 0 = read.
- `wdata` out WIDTH: write data.
- `valid` out 1: request valid.
- `rdata` in WIDTH: read data from memory.
- `ready` in 1: memory accepts the request.
- `busy` out 1: run in progress.
- `done` out 1: run finished; held until the next accepted start.
- `pass` out 1: `done` and zero errors and no timeout.
- `timeout` out 1: run aborted on ready timeout.
- `err_count` out ERR_W: read-compare mismatches; saturates at all-ones.
- `first_err_addr` out ADDR_WIDTH: address of the first mismatch.
- `first_err_pass` out 1: pass (0 or 1) of the first mismatch.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- Handshake: a transfer occurs on a rising edge where `valid && ready`.
  - The request fields are stable while `valid` is high and `ready` is low.
  - For reads, `rdata` is sampled on that same edge.
- Pattern for address a:
  - Pass 0 uses P(a) = seed_latched ^ zero-extend(a).
  - Pass 1 uses ~P(a).
- Transitions:
  - IDLE/DONE → WR0 on `start`. On entry: latch seed, clear err_count, first_err_*, timeout, done and pass.
  - WR0 → RD0, RD0 → WR1, WR1 → RD1: each on the transfer at address DEPTH-1.
  - RD1 → DONE on the transfer at address DEPTH-1.
  - Any active state → DONE on timeout.
- Within a pass, the address runs 0 up to DEPTH-1. On each transfer, `addr` increments and the next request is presented the following cycle with `valid` kept high (back-to-back). The address wraps to 0 at each pass change.
- Read compare: on a read transfer with `rdata` != expected, err_count increments (saturating). first_err_addr and first_err_pass are captured only while err_count == 0.
- Timeout counter:
  - Counts cycles with `valid && !ready`.
  - Clears on each transfer.
  - Reaching TIMEOUT drops `valid`, sets `timeout`, and enters DONE.
- `start` while busy is ignored.
- In DONE, `valid` = 0 and `busy` = 0.

## Timing
- Reset values: valid 0, addr 0, wr_rd 0, wdata 0, busy 0, done 0, pass 0, timeout 0, err_count 0, first_err_addr 0, first_err_pass 0. State is IDLE.
- Reset asserted mid-run returns to these values immediately (asynchronous) and abandons the request.
- Start:
  - `start` is sampled high at edge T0 in IDLE/DONE.
  - After T0: busy = 1, valid = 1, wr_rd = 1, addr = 0, wdata = seed.
- With `ready` held high, the run has 4*DEPTH transfers at edges T1..T4·DEPTH. After edge T4·DEPTH: done = 1, busy = 0, valid = 0, pass valid.
  - For DEPTH = 64, done appears 256 cycles after the start edge.
- Each wait cycle (ready low) adds exactly one cycle of latency; there are no bubbles between transfers.
- Outputs are registered; there is no combinational path from `ready`/`rdata` to any output.

## Test plan
- Clean run: DEPTH = 64, ideal memory, ready always 1, seed = 16'hA5A5 → 256 transfers. Address 3 is written 16'hA5A6 in pass 0 and 16'h5A59 in pass 1. done at +256 cycles, pass = 1, err_count = 0.
- Stuck bit: memory model forces rdata[3] = 0 at address 5, seed = 16'h00FF → err_count = 1, first_err_addr = 5, first_err_pass = 0, pass = 0. Pass 1 data 16'hFF05 matches.
- Wait states: ready low for 2 cycles before every transfer → no bubbles, done at +768 cycles, request fields stable while waiting, pass = 1.
- Timeout: ready stuck low from the 10th write (address 9) → after 32 wait cycles: valid = 0, timeout = 1, done = 1, pass = 0, busy = 0.
- Start while busy: pulse `start` with seed = 16'h1234 during RD0 → ignored; the original seed pattern continues and the run completes normally.
- Reset mid-run: assert `rst` low during WR1 → all outputs return to their reset values within the same cycle. A new start then completes with pass = 1.
